// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational
// instruction memory. The fetch stage drives the address. The memory
// returns the word at that address in the same cycle.
interface fetch_stage_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the PA-RISC two-entry address queue.
// front_q is the address being fetched now. back_q is the next address.
// It also holds the IF/ID pipeline register.
//
// Flow control: there is no valid/ready pair here. LE acts as the single
// downstream "ready": when LE=1 the queue advances and IF/ID loads. When LE=0
// everything holds. The only exceptions are NULLIFY, which still clears IF/ID,
// and BR_TAKEN, which is latched as a pending redirect.
module fetch_stage #(
    parameter int              ADDR_W   = 8,
    parameter logic [31:0]     NOP_WORD = 32'h0000_0000,
    parameter int              CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              LE,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] TA,
    input  logic              NULLIFY,
    fetch_stage_if.master     imem,
    output logic [31:0]       instruction_out,
    output logic [ADDR_W-1:0] pc_id_out,
    output logic [ADDR_W-1:0] front_q_out,
    output logic [ADDR_W-1:0] back_q_out,
    output logic              valid_out,
    output logic              br_pending_out,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] front_q, front_nxt;
    logic [ADDR_W-1:0] back_q, back_nxt;
    logic [ADDR_W-1:0] pend_ta, pend_ta_nxt;
    logic [ADDR_W-1:0] ta_aligned;

    // Branch targets are word aligned; the low two bits of TA are ignored.
    assign ta_aligned = {TA[ADDR_W-1:2], 2'b00};

    assign imem.imem_addr  = front_q;
    assign front_q_out     = front_q;
    assign back_q_out      = back_q;
    assign br_pending_out  = (state == PEND);

    // State and queue registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            front_q <= '0;
            back_q  <= ADDR_W'(4);
            pend_ta <= '0;
        end else begin
            state   <= state_nxt;
            front_q <= front_nxt;
            back_q  <= back_nxt;
            pend_ta <= pend_ta_nxt;
        end
    end

    // Next-state and queue update. The delay slot (old back_q) always moves to
    // the front. A branch only redirects the address after the delay slot.
    always_comb begin
        state_nxt   = state;
        front_nxt   = front_q;
        back_nxt    = back_q;
        pend_ta_nxt = pend_ta;
        case (state)
            IDLE: begin
                if (LE) begin
                    front_nxt = back_q;
                    back_nxt  = BR_TAKEN ? ta_aligned : back_q + ADDR_W'(4);
                end else if (BR_TAKEN) begin
                    pend_ta_nxt = ta_aligned;
                    state_nxt   = PEND;
                end
            end
            PEND: begin
                if (LE) begin
                    front_nxt = back_q;
                    // A branch resolved in the same cycle overrides the latched one.
                    back_nxt  = BR_TAKEN ? ta_aligned : pend_ta;
                    state_nxt = IDLE;
                end else if (BR_TAKEN) begin
                    pend_ta_nxt = ta_aligned;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IF/ID register. NULLIFY squashes the slot whether or not LE is set.
    // The fetch counter only counts real, unsquashed loads.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            instruction_out <= NOP_WORD;
            pc_id_out       <= '0;
            valid_out       <= 1'b0;
            fetch_count     <= '0;
        end else if (NULLIFY) begin
            instruction_out <= NOP_WORD;
            valid_out       <= 1'b0;
            if (LE) pc_id_out <= front_q;
        end else if (LE) begin
            instruction_out <= imem.imem_data;
            pc_id_out       <= front_q;
            valid_out       <= 1'b1;
            if (fetch_count != {CNT_W{1'b1}}) fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The bench ROM returns
// 32'hA000_0000 | addr for every address.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst, LE, BR_TAKEN, NULLIFY;
    logic [7:0]  TA;
    logic [31:0] instruction_out;
    logic [7:0]  pc_id_out, front_q_out, back_q_out;
    logic        valid_out, br_pending_out;
    logic [15:0] fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_stage_if #(.ADDR_W(8)) imem ();

    // Combinational ROM model
    assign imem.imem_data = 32'hA000_0000 | {24'h0, imem.imem_addr};

    fetch_stage #(.ADDR_W(8), .NOP_WORD(32'h0000_0000), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .LE(LE), .BR_TAKEN(BR_TAKEN), .TA(TA),
        .NULLIFY(NULLIFY), .imem(imem.master),
        .instruction_out(instruction_out), .pc_id_out(pc_id_out),
        .front_q_out(front_q_out), .back_q_out(back_q_out),
        .valid_out(valid_out), .br_pending_out(br_pending_out),
        .fetch_count(fetch_count)
    );

    // Clock
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle; inputs change #1 after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic rst, input logic le, input logic br,
                          input logic [7:0] ta, input logic nul);
        Rst = rst; LE = le; BR_TAKEN = br; TA = ta; NULLIFY = nul;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 8'h00, 0);
        step();
        total++; if (front_q_out !== 8'd0) begin bad++; $display("FAIL reset_front got %0d want 0", front_q_out); end
        total++; if (back_q_out !== 8'd4) begin bad++; $display("FAIL reset_back got %0d want 4", back_q_out); end
        total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", instruction_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_out); end
        total++; if (pc_id_out !== 8'd0) begin bad++; $display("FAIL reset_pc got %0d want 0", pc_id_out); end
        total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        total++; if (br_pending_out !== 1'b0) begin bad++; $display("FAIL reset_pend got %b want 0", br_pending_out); end
    endtask

    task automatic test_sequential();
        set_in(0, 1, 0, 8'h00, 0);
        step();
        total++; if (front_q_out !== 8'd4) begin bad++; $display("FAIL seq1_front got %0d want 4", front_q_out); end
        total++; if (back_q_out !== 8'd8) begin bad++; $display("FAIL seq1_back got %0d want 8", back_q_out); end
        total++; if (instruction_out !== 32'hA000_0000) begin bad++; $display("FAIL seq1_instr got %h want a0000000", instruction_out); end
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL seq1_valid got %b want 1", valid_out); end
        step();
        step();
        total++; if (front_q_out !== 8'd12) begin bad++; $display("FAIL seq3_front got %0d want 12", front_q_out); end
        total++; if (pc_id_out !== 8'd8) begin bad++; $display("FAIL seq3_pc got %0d want 8", pc_id_out); end
        total++; if (instruction_out !== 32'hA000_0008) begin bad++; $display("FAIL seq3_instr got %h want a0000008", instruction_out); end
        total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL seq3_count got %0d want 3", fetch_count); end
    endtask

    task automatic test_stall();
        set_in(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (front_q_out !== 8'd12 || back_q_out !== 8'd16) begin bad++; $display("FAIL stall_queue got %0d/%0d want 12/16", front_q_out, back_q_out); end
            total++; if (instruction_out !== 32'hA000_0008 || fetch_count !== 16'd3) begin bad++; $display("FAIL stall_ifid got %h/%0d want a0000008/3", instruction_out, fetch_count); end
        end
        LE = 1;
        step();
        total++; if (front_q_out !== 8'd16) begin bad++; $display("FAIL stall_resume_front got %0d want 16", front_q_out); end
        total++; if (instruction_out !== 32'hA000_000C || fetch_count !== 16'd4) begin bad++; $display("FAIL stall_resume_ifid got %h/%0d want a000000c/4", instruction_out, fetch_count); end
    endtask

    task automatic test_branch();
        set_in(1, 0, 0, 8'h00, 0);
        step();
        set_in(0, 1, 0, 8'h00, 0);
        step();
        step();
        // front_q=8, back_q=12 here
        set_in(0, 1, 1, 8'h43, 0);
        step();
        total++; if (front_q_out !== 8'd12 || back_q_out !== 8'd64) begin bad++; $display("FAIL br_queue got %0d/%0d want 12/64", front_q_out, back_q_out); end
        set_in(0, 1, 0, 8'h00, 0);
        step();
        total++; if (front_q_out !== 8'd64 || back_q_out !== 8'd68) begin bad++; $display("FAIL br_slot_queue got %0d/%0d want 64/68", front_q_out, back_q_out); end
        total++; if (instruction_out !== 32'hA000_000C) begin bad++; $display("FAIL br_delay_slot got %h want a000000c", instruction_out); end
        step();
        total++; if (instruction_out !== 32'hA000_0040 || pc_id_out !== 8'd64) begin bad++; $display("FAIL br_target got %h/%0d want a0000040/64", instruction_out, pc_id_out); end
    endtask

    task automatic test_branch_stalled();
        // front 68, back 72, count 5
        set_in(0, 0, 1, 8'd100, 0);
        step();
        total++; if (br_pending_out !== 1'b1) begin bad++; $display("FAIL pend_set got %b want 1", br_pending_out); end
        total++; if (front_q_out !== 8'd68 || back_q_out !== 8'd72) begin bad++; $display("FAIL pend_hold got %0d/%0d want 68/72", front_q_out, back_q_out); end
        set_in(0, 1, 0, 8'h00, 0);
        step();
        total++; if (front_q_out !== 8'd72 || back_q_out !== 8'd100) begin bad++; $display("FAIL pend_release got %0d/%0d want 72/100", front_q_out, back_q_out); end
        total++; if (br_pending_out !== 1'b0) begin bad++; $display("FAIL pend_clear got %b want 0", br_pending_out); end
        // Latest pending target wins
        set_in(0, 0, 1, 8'd100, 0);
        step();
        set_in(0, 0, 1, 8'd200, 0);
        step();
        set_in(0, 1, 0, 8'h00, 0);
        step();
        total++; if (front_q_out !== 8'd100 || back_q_out !== 8'd200) begin bad++; $display("FAIL pend_latest got %0d/%0d want 100/200", front_q_out, back_q_out); end
        // A new branch on the release edge overrides the pending one
        set_in(0, 0, 1, 8'd8, 0);
        step();
        set_in(0, 1, 1, 8'd13, 0);
        step();
        total++; if (front_q_out !== 8'd200 || back_q_out !== 8'd12) begin bad++; $display("FAIL pend_override got %0d/%0d want 200/12", front_q_out, back_q_out); end
        total++; if (fetch_count !== 16'd8) begin bad++; $display("FAIL pend_count got %0d want 8", fetch_count); end
    endtask

    task automatic test_nullify();
        set_in(0, 1, 0, 8'h00, 1);
        step();
        total++; if (instruction_out !== 32'h0 || valid_out !== 1'b0) begin bad++; $display("FAIL nul_le_ifid got %h/%b want 0/0", instruction_out, valid_out); end
        total++; if (fetch_count !== 16'd8 || pc_id_out !== 8'd200) begin bad++; $display("FAIL nul_le_cnt_pc got %0d/%0d want 8/200", fetch_count, pc_id_out); end
        total++; if (front_q_out !== 8'd12 || back_q_out !== 8'd16) begin bad++; $display("FAIL nul_le_queue got %0d/%0d want 12/16", front_q_out, back_q_out); end
        set_in(0, 1, 0, 8'h00, 0);
        step();
        total++; if (instruction_out !== 32'hA000_000C || valid_out !== 1'b1 || fetch_count !== 16'd9) begin bad++; $display("FAIL nul_after got %h/%b/%0d want a000000c/1/9", instruction_out, valid_out, fetch_count); end
        set_in(0, 0, 0, 8'h00, 1);
        step();
        total++; if (instruction_out !== 32'h0 || valid_out !== 1'b0 || pc_id_out !== 8'd12) begin bad++; $display("FAIL nul_stall_ifid got %h/%b/%0d want 0/0/12", instruction_out, valid_out, pc_id_out); end
        total++; if (front_q_out !== 8'd16 || back_q_out !== 8'd20 || fetch_count !== 16'd9) begin bad++; $display("FAIL nul_stall_hold got %0d/%0d/%0d want 16/20/9", front_q_out, back_q_out, fetch_count); end
        set_in(0, 1, 1, 8'h31, 1);
        step();
        total++; if (front_q_out !== 8'd20 || back_q_out !== 8'd48 || valid_out !== 1'b0) begin bad++; $display("FAIL nul_branch got %0d/%0d/%b want 20/48/0", front_q_out, back_q_out, valid_out); end
    endtask

    task automatic test_wrap_and_reset();
        set_in(1, 0, 0, 8'h00, 0);
        step();
        set_in(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 62; i++) step();
        total++; if (front_q_out !== 8'd248 || back_q_out !== 8'd252) begin bad++; $display("FAIL wrap_pre got %0d/%0d want 248/252", front_q_out, back_q_out); end
        step();
        step();
        total++; if (front_q_out !== 8'd0 || back_q_out !== 8'd4) begin bad++; $display("FAIL wrap_post got %0d/%0d want 0/4", front_q_out, back_q_out); end
        total++; if (instruction_out !== 32'hA000_00FC || pc_id_out !== 8'd252 || fetch_count !== 16'd64) begin bad++; $display("FAIL wrap_ifid got %h/%0d/%0d want a00000fc/252/64", instruction_out, pc_id_out, fetch_count); end
        set_in(0, 0, 1, 8'd80, 0);
        step();
        total++; if (br_pending_out !== 1'b1) begin bad++; $display("FAIL mid_pend got %b want 1", br_pending_out); end
        set_in(1, 0, 0, 8'h00, 0);
        step();
        total++; if (front_q_out !== 8'd0 || back_q_out !== 8'd4 || br_pending_out !== 1'b0) begin bad++; $display("FAIL mid_reset_q got %0d/%0d/%b want 0/4/0", front_q_out, back_q_out, br_pending_out); end
        total++; if (fetch_count !== 16'd0 || valid_out !== 1'b0 || instruction_out !== 32'h0) begin bad++; $display("FAIL mid_reset_ifid got %0d/%b/%h want 0/0/0", fetch_count, valid_out, instruction_out); end
        set_in(0, 1, 0, 8'h00, 0);
        step();
        total++; if (back_q_out !== 8'd8 || front_q_out !== 8'd4) begin bad++; $display("FAIL mid_reset_nopend got %0d/%0d want 4/8", front_q_out, back_q_out); end
    endtask

    initial begin
        set_in(1, 0, 0, 8'h00, 0);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stalled();
        test_nullify();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
